// File: rtl/l1_readout_sched_pkg.sv
// Shared widths, default sizing and FSM state encoding for the L1/R3 readout scheduler.
// The readout ID width comes from `RO_ADDR_WIDTH (12 bits when the build does not set it).
`ifndef RO_ADDR_WIDTH
`define RO_ADDR_WIDTH 12
`endif

package l1_readout_sched_pkg;

    localparam int SCHED_ADDR_W    = `RO_ADDR_WIDTH;
    localparam int SCHED_DEPTH_DEF = 8;
    localparam int SCHED_TMO_W_DEF = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_REQ  = 2'd1,
        SCHED_BUSY = 2'd2
    } sched_state_e;

endpackage

// File: rtl/l1_sched_fifo.sv
// Synchronous FIFO holding pending L1 event IDs; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module l1_sched_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     Resetb,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [CW-1:0] count_nxt_s;

    // Accepted push/pop this cycle and the resulting occupancy.
    always_comb begin
        pop_ok_s    = pop && !empty;
        push_ok_s   = push && (!full || pop_ok_s);
        count_nxt_s = count;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_nxt_s = count - CW'(1);
        end else begin
            count_nxt_s = count;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!Resetb) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            count <= count_nxt_s;
            full  <= (count_nxt_s == CW'(DEPTH));
            empty <= (count_nxt_s == CW'(0));
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];

endmodule

// File: rtl/l1_readout_sched.sv
// Readout request scheduler: queued L1 IDs plus a one-entry R3 priority slot, one
// req/ack/done handshake with a done watchdog. Optional macro: L1_SCHED_OVFCNT_EN.
module l1_readout_sched
    import l1_readout_sched_pkg::*;
#(
    parameter int ADDR_W = SCHED_ADDR_W,
    parameter int DEPTH  = SCHED_DEPTH_DEF,
    parameter int TMO_W  = SCHED_TMO_W_DEF
) (
    input  logic              clk,
    input  logic              Resetb,
    input  logic              L1detAck,
    input  logic [ADDR_W-1:0] L1L0ID,
    input  logic              R3detAck,
    input  logic [ADDR_W-1:0] R3L0ID,
    output logic              ReadReq,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic              ReadIsR3,
    input  logic              ReadAck,
    input  logic              ReadDone,
    output logic              L1Empty,
    output logic              L1Full,
    output logic              L1Drop,
    output logic              R3Drop,
    output logic              Timeout
`ifdef L1_SCHED_OVFCNT_EN
    ,
    output logic [7:0]        DropCount
`endif
);

    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [TMO_W-1:0]  TMO_MAX = {TMO_W{1'b1}};

    sched_state_e      state_r;
    logic [TMO_W-1:0]  wdog_r;
    logic              r3_pend_r;
    logic [ADDR_W-1:0] r3_id_r;

    logic [ADDR_W-1:0] fifo_head_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              r3_take_s;
    logic              l1_pop_s;
    logic              l1_push_s;
    logic              l1_drop_s;
    logic              r3_drop_s;

    // R3 always wins the idle slot; a full FIFO only drops when nothing pops this cycle.
    always_comb begin
        r3_take_s = (state_r == SCHED_IDLE) && r3_pend_r;
        l1_pop_s  = (state_r == SCHED_IDLE) && !r3_pend_r && !fifo_empty_s;
        l1_drop_s = L1detAck && (fifo_count_s == CNT_W'(DEPTH)) && !l1_pop_s;
        l1_push_s = L1detAck && !l1_drop_s;
        r3_drop_s = R3detAck && r3_pend_r && !r3_take_s;
    end

    l1_sched_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .Resetb (Resetb),
        .push   (l1_push_s),
        .wdata  (L1L0ID),
        .pop    (l1_pop_s),
        .rdata  (fifo_head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

    assign L1Empty = fifo_empty_s;
    assign L1Full  = fifo_full_s;

    // R3 priority slot: a new ID always lands, even in the cycle the old one is taken.
    always_ff @(posedge clk) begin
        if (!Resetb) begin
            r3_pend_r <= 1'b0;
            r3_id_r   <= '0;
        end else if (R3detAck) begin
            r3_pend_r <= 1'b1;
            r3_id_r   <= R3L0ID;
        end else if (r3_take_s) begin
            r3_pend_r <= 1'b0;
        end else begin
            r3_pend_r <= r3_pend_r;
        end
    end

    // Handshake FSM with registered request outputs and done watchdog.
    always_ff @(posedge clk) begin
        if (!Resetb) begin
            state_r  <= SCHED_IDLE;
            ReadReq  <= 1'b0;
            ReadAddr <= '0;
            ReadIsR3 <= 1'b0;
            Timeout  <= 1'b0;
            wdog_r   <= '0;
        end else begin
            Timeout <= 1'b0;
            case (state_r)
                SCHED_IDLE: begin
                    if (r3_pend_r) begin
                        state_r  <= SCHED_REQ;
                        ReadReq  <= 1'b1;
                        ReadAddr <= r3_id_r;
                        ReadIsR3 <= 1'b1;
                    end else if (!fifo_empty_s) begin
                        state_r  <= SCHED_REQ;
                        ReadReq  <= 1'b1;
                        ReadAddr <= fifo_head_s;
                        ReadIsR3 <= 1'b0;
                    end else begin
                        state_r <= SCHED_IDLE;
                    end
                end
                SCHED_REQ: begin
                    if (ReadAck) begin
                        state_r <= SCHED_BUSY;
                        ReadReq <= 1'b0;
                        wdog_r  <= '0;
                    end else begin
                        state_r <= SCHED_REQ;
                    end
                end
                SCHED_BUSY: begin
                    if (ReadDone) begin
                        state_r <= SCHED_IDLE;
                    end else if (wdog_r == TMO_MAX) begin
                        state_r <= SCHED_IDLE;
                        Timeout <= 1'b1;
                    end else begin
                        wdog_r <= wdog_r + TMO_W'(1);
                    end
                end
                default: begin
                    state_r <= SCHED_IDLE;
                    ReadReq <= 1'b0;
                end
            endcase
        end
    end

    // Loss indications, one cycle after the offending detector pulse.
    always_ff @(posedge clk) begin
        if (!Resetb) begin
            L1Drop <= 1'b0;
            R3Drop <= 1'b0;
        end else begin
            L1Drop <= l1_drop_s;
            R3Drop <= r3_drop_s;
        end
    end

`ifdef L1_SCHED_OVFCNT_EN
    // Saturating loss counter; simultaneous L1 and R3 losses count once.
    always_ff @(posedge clk) begin
        if (!Resetb) begin
            DropCount <= 8'd0;
        end else if ((l1_drop_s || r3_drop_s) && (DropCount != 8'hFF)) begin
            DropCount <= DropCount + 8'd1;
        end else begin
            DropCount <= DropCount;
        end
    end
`endif

endmodule

// File: tb/tb_l1_readout_sched.sv
// Scoreboard bench for l1_readout_sched: issued IDs are queued as stimulus is driven
// and compared in order as each request appears on the readout handshake.
module tb_l1_readout_sched;
    import l1_readout_sched_pkg::*;

    localparam int AW = SCHED_ADDR_W;

    logic          clk = 1'b0;
    logic          Resetb;
    logic          L1detAck;
    logic [AW-1:0] L1L0ID;
    logic          R3detAck;
    logic [AW-1:0] R3L0ID;
    logic          ReadReq;
    logic [AW-1:0] ReadAddr;
    logic          ReadIsR3;
    logic          ReadAck;
    logic          ReadDone;
    logic          L1Empty;
    logic          L1Full;
    logic          L1Drop;
    logic          R3Drop;
    logic          Timeout;
`ifdef L1_SCHED_OVFCNT_EN
    logic [7:0]    DropCount;
`endif

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] l1_model[$];
    logic          r3_pend_m = 1'b0;
    logic [AW-1:0] r3_id_m   = '0;

    always #5 clk = ~clk;

    l1_readout_sched dut (
        .clk      (clk),
        .Resetb   (Resetb),
        .L1detAck (L1detAck),
        .L1L0ID   (L1L0ID),
        .R3detAck (R3detAck),
        .R3L0ID   (R3L0ID),
        .ReadReq  (ReadReq),
        .ReadAddr (ReadAddr),
        .ReadIsR3 (ReadIsR3),
        .ReadAck  (ReadAck),
        .ReadDone (ReadDone),
        .L1Empty  (L1Empty),
        .L1Full   (L1Full),
        .L1Drop   (L1Drop),
        .R3Drop   (R3Drop),
        .Timeout  (Timeout)
`ifdef L1_SCHED_OVFCNT_EN
        ,
        .DropCount(DropCount)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_l1(input logic [AW-1:0] id, input bit kept);
        L1detAck = 1'b1;
        L1L0ID   = id;
        if (kept) l1_model.push_back(id);
        tick();
        L1detAck = 1'b0;
    endtask

    task automatic send_r3(input logic [AW-1:0] id);
        R3detAck  = 1'b1;
        R3L0ID    = id;
        r3_pend_m = 1'b1;
        r3_id_m   = id;
        tick();
        R3detAck = 1'b0;
    endtask

    task automatic wait_req(input string tag, output bit ok);
        int n = 0;
        while (ReadReq !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        ok = (ReadReq === 1'b1);
        check_val({tag, "_req"}, 32'(ReadReq), 32'd1);
    endtask

    task automatic expect_next(input string tag);
        logic          e_r3;
        logic [AW-1:0] e_addr;
        if (r3_pend_m) begin
            e_r3      = 1'b1;
            e_addr    = r3_id_m;
            r3_pend_m = 1'b0;
        end else if (l1_model.size() > 0) begin
            e_r3   = 1'b0;
            e_addr = l1_model.pop_front();
        end else begin
            checks++;
            failures++;
            $display("FAIL %s_sb: request 0x%0h issued but scoreboard empty", tag, ReadAddr);
            return;
        end
        check_val({tag, "_addr"}, 32'(ReadAddr), 32'(e_addr));
        check_val({tag, "_isr3"}, 32'(ReadIsR3), 32'(e_r3));
    endtask

    task automatic serve_one(input string tag);
        bit ok;
        wait_req(tag, ok);
        if (ok) begin
            expect_next(tag);
            ReadAck = 1'b1;
            tick();
            ReadAck = 1'b0;
            tick();
            tick();
            ReadDone = 1'b1;
            tick();
            ReadDone = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int drops;
        int n;
        Resetb = 1'b0; L1detAck = 1'b0; L1L0ID = '0; R3detAck = 1'b0; R3L0ID = '0;
        ReadAck = 1'b0; ReadDone = 1'b0;
        repeat (3) tick();
        check_val("rst_req",   32'(ReadReq),  32'd0);
        check_val("rst_addr",  32'(ReadAddr), 32'd0);
        check_val("rst_isr3",  32'(ReadIsR3), 32'd0);
        check_val("rst_empty", 32'(L1Empty),  32'd1);
        check_val("rst_full",  32'(L1Full),   32'd0);
        check_val("rst_pulses", {29'd0, L1Drop, R3Drop, Timeout}, 32'd0);
`ifdef L1_SCHED_OVFCNT_EN
        check_val("rst_dropcnt", 32'(DropCount), 32'd0);
`endif
        Resetb = 1'b1;
        tick();

        // 1: single L1 request latency and handshake
        send_l1(AW'(32'h15), 1'b1);
        check_val("t1_req_n1", 32'(ReadReq), 32'd0);
        tick();
        check_val("t1_req_n2", 32'(ReadReq), 32'd1);
        expect_next("t1");
        ReadAck = 1'b1; tick(); ReadAck = 1'b0;
        tick(); tick();
        ReadDone = 1'b1; tick(); ReadDone = 1'b0;
        check_val("t1_idle_req",   32'(ReadReq), 32'd0);
        check_val("t1_idle_empty", 32'(L1Empty), 32'd1);
        tick();
        check_val("t1_idle_req2",  32'(ReadReq), 32'd0);

        // 2: R3 arriving mid-transaction overtakes queued L1 IDs
        send_l1(AW'(32'h1), 1'b1);
        send_l1(AW'(32'h2), 1'b1);
        send_l1(AW'(32'h3), 1'b1);
        wait_req("t2_first", ok);
        if (ok) begin
            expect_next("t2_first");
            ReadAck = 1'b1; tick(); ReadAck = 1'b0;
            send_r3(AW'(32'h40));
            check_val("t2_r3drop", 32'(R3Drop), 32'd0);
            ReadDone = 1'b1; tick(); ReadDone = 1'b0;
        end
        for (int i = 0; i < 3; i++) serve_one($sformatf("t2_%0d", i));
        check_val("t2_empty", 32'(L1Empty), 32'd1);

        // 3: stall on ReadAck, overfill the FIFO by one
        send_l1(AW'(32'h70), 1'b1);
        wait_req("t3_hold", ok);
        expect_next("t3_hold");
        drops = 0;
        for (int i = 0; i < 9; i++) begin
            send_l1(AW'(32'h21 + i), (i < 8));
            if (L1Drop === 1'b1) drops++;
        end
        check_val("t3_drops", 32'(drops), 32'd1);
        check_val("t3_full",  32'(L1Full), 32'd1);
`ifdef L1_SCHED_OVFCNT_EN
        check_val("t3_dropcnt", 32'(DropCount), 32'd1);
`endif
        ReadDone = 1'b1; tick(); ReadDone = 1'b0;
        check_val("t3_done_ignored", 32'(ReadReq), 32'd1);

        // 4: full FIFO with simultaneous push and pop
        ReadAck = 1'b1; tick(); ReadAck = 1'b0;
        ReadDone = 1'b1; tick(); ReadDone = 1'b0;
        send_l1(AW'(32'h2A), 1'b1);
        check_val("t4_nodrop", 32'(L1Drop), 32'd0);
        check_val("t4_full",   32'(L1Full), 32'd1);

        // 5: two R3 IDs during one transaction, the later one survives
        wait_req("t5_cur", ok);
        if (ok) begin
            expect_next("t5_cur");
            ReadAck = 1'b1; tick(); ReadAck = 1'b0;
            send_r3(AW'(32'h10));
            check_val("t5_r3drop_a", 32'(R3Drop), 32'd0);
            send_r3(AW'(32'h11));
            check_val("t5_r3drop_b", 32'(R3Drop), 32'd1);
            ReadDone = 1'b1; tick(); ReadDone = 1'b0;
        end
`ifdef L1_SCHED_OVFCNT_EN
        check_val("t5_dropcnt", 32'(DropCount), 32'd2);
`endif
        for (int i = 0; i < 9; i++) serve_one($sformatf("t5_%0d", i));
        check_val("t5_empty", 32'(L1Empty), 32'd1);

        // 6: watchdog timeout, then reset during an outstanding request
        send_l1(AW'(32'h31), 1'b1);
        send_l1(AW'(32'h32), 1'b1);
        wait_req("t6_a", ok);
        expect_next("t6_a");
        ReadAck = 1'b1; tick(); ReadAck = 1'b0;
        n = 0;
        while (Timeout !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check_val("t6_timeout_seen", 32'(Timeout), 32'd1);
        check_val("t6_timeout_window", 32'(n >= 255 && n <= 257), 32'd1);
        tick();
        check_val("t6_timeout_pulse", 32'(Timeout), 32'd0);
        wait_req("t6_b", ok);
        expect_next("t6_b");
        send_l1(AW'(32'h33), 1'b1);
        check_val("t6_nonempty", 32'(L1Empty), 32'd0);
        Resetb = 1'b0;
        tick();
        l1_model.delete();
        r3_pend_m = 1'b0;
        check_val("t6_rst_req",   32'(ReadReq), 32'd0);
        check_val("t6_rst_empty", 32'(L1Empty), 32'd1);
        Resetb = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
